// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous-read data RAM between the CPU
// datapath and a DMA/program-loader master.
//
// Every granted access runs IDLE -> ISSUE -> WAIT -> IDLE. The ack pulse and the read data
// come from registers and are visible in the IDLE cycle that follows WAIT.
//
// Ports:
//   clk, reset              system clock; synchronous active-high reset
//   cpu_req/write/addr/wdata CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack      registered read data and one-cycle completion pulse
//   dma_*                   same set for the DMA/loader port
//   mem_addr/wdata/write    RAM address, write data and write strobe (from latched request)
//   mem_rdata               RAM read data, valid one cycle after the address
//   owner                   current owner: 00 none, 01 CPU, 10 DMA
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_write,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [1:0] OwnerNone = 2'b00;
    localparam logic [1:0] OwnerCpu  = 2'b01;
    localparam logic [1:0] OwnerDma  = 2'b10;

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                last_dma_q, last_dma_d;  // 1: DMA was granted most recently
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

    logic cpu_eff, dma_eff;
    logic grant_cpu, grant_dma;

    // A master's request is still high in its own ack cycle; mask it so it is not re-granted.
    assign cpu_eff = cpu_req & ~cpu_ack_q;
    assign dma_eff = dma_req & ~dma_ack_q;

    // On a tie, the port that was not granted last wins.
    assign grant_cpu = cpu_eff & (~dma_eff | last_dma_q);
    assign grant_dma = dma_eff & (~cpu_eff | ~last_dma_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_dma_d  = last_dma_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_cpu) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    write_d    = cpu_write;
                    owner_d    = OwnerCpu;
                    last_dma_d = 1'b0;
                    state_d    = StIssue;
                end else if (grant_dma) begin
                    addr_d     = dma_addr;
                    wdata_d    = dma_wdata;
                    write_d    = dma_write;
                    owner_d    = OwnerDma;
                    last_dma_d = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (owner_q == OwnerCpu) begin
                    cpu_ack_d = 1'b1;
                    if (!write_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end else if (owner_q == OwnerDma) begin
                    dma_ack_d = 1'b1;
                    if (!write_q) begin
                        dma_rdata_d = mem_rdata;
                    end
                end
                owner_d = OwnerNone;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnerNone;
            last_dma_q  <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_dma_q  <= last_dma_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    // Strobe is decoded from state, so a write in ISSUE still lands even if reset is high.
    assign mem_write = (state_q == StIssue) & write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a bench-side RAM, a transaction-level
// reference model checked every cycle, and literal expectations for the directed scenarios.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_req = 1'b0, cpu_write = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       dma_req = 1'b0, dma_write = 1'b0;
    logic [7:0] dma_addr = '0, dma_wdata = '0;
    logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       cpu_ack, dma_ack, mem_write;
    logic [1:0] owner;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [7:0] init_val(int i);
        case (i)
            8'h10:   return 8'hA5;
            8'h01:   return 8'h11;
            8'h02:   return 8'h22;
            8'h03:   return 8'h33;
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Synchronous-read RAM: data for the address seen at an edge appears after that edge.
    logic [7:0] ram [256];
    logic       ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] = init_val(i);
            ram_init = 1'b1;
        end
        mem_rdata <= ram[mem_addr];
        if (mem_write === 1'b1) ram[mem_addr] = mem_wdata;
    end

    // Write-strobe monitor used by directed checks.
    int         mw_cnt = 0;
    logic [7:0] mw_addr = '0, mw_data = '0;
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            mw_cnt++;
            mw_addr = mem_addr;
            mw_data = mem_wdata;
        end
    end

    // Reference model: one in-flight transaction stamped with its grant cycle g. The access
    // occupies cycles g+1 and g+2, the ack shows in g+3. Checked at every falling edge.
    int         cyc = 0, g = 0;
    logic       armed = 1'b0, has_tx = 1'b0;
    logic       m_port = 1'b0;  // 0 CPU, 1 DMA
    logic       m_write = 1'b0, m_last_dma = 1'b1;
    logic [7:0] m_addr = '0, m_wdata = '0;
    logic       m_cpu_ack = 1'b0, m_dma_ack = 1'b0;
    logic [7:0] m_cpu_rdata = '0, m_dma_rdata = '0;
    logic [7:0] shadow [256];

    always @(negedge clk) begin
        logic [1:0] exp_owner;
        logic       exp_mw, nx_cpu_ack, nx_dma_ack, idle, ce, de;
        if (armed) begin
            exp_owner = 2'b00;
            exp_mw    = 1'b0;
            if (has_tx) begin
                exp_owner = m_port ? 2'b10 : 2'b01;
                exp_mw    = m_write && (cyc == g + 1);
            end
            check("cpu_ack", cpu_ack, m_cpu_ack);
            check("dma_ack", dma_ack, m_dma_ack);
            check("cpu_rdata", cpu_rdata, m_cpu_rdata);
            check("dma_rdata", dma_rdata, m_dma_rdata);
            check("owner", owner, exp_owner);
            check("mem_write", mem_write, exp_mw);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        if (has_tx && m_write && cyc == g + 1) shadow[m_addr] = m_wdata;
        nx_cpu_ack = has_tx && (cyc == g + 2) && !m_port;
        nx_dma_ack = has_tx && (cyc == g + 2) && m_port;
        if (has_tx && cyc == g + 2 && !m_write) begin
            if (!m_port) m_cpu_rdata = shadow[m_addr];
            else         m_dma_rdata = shadow[m_addr];
        end
        idle = !has_tx;
        if (has_tx && cyc == g + 2) has_tx = 1'b0;
        ce = cpu_req && !m_cpu_ack;
        de = dma_req && !m_dma_ack;
        if (idle && (ce || de)) begin
            has_tx = 1'b1;
            g      = cyc;
            m_port = (ce && de) ? !m_last_dma : de;
            m_last_dma = m_port;
            m_write = m_port ? dma_write : cpu_write;
            m_addr  = m_port ? dma_addr  : cpu_addr;
            m_wdata = m_port ? dma_wdata : cpu_wdata;
        end
        m_cpu_ack = nx_cpu_ack;
        m_dma_ack = nx_dma_ack;
        if (reset) begin
            if (!armed) for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
            armed = 1'b1;
            has_tx = 1'b0;
            m_last_dma = 1'b1;
            m_write = 1'b0;
            m_addr = '0;
            m_wdata = '0;
            m_cpu_ack = 1'b0;
            m_dma_ack = 1'b0;
            m_cpu_rdata = '0;
            m_dma_rdata = '0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles from request to ack, or 0 if none within the bound.
    task automatic wait_ack(input logic port, output int n);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if ((port ? dma_ack : cpu_ack) === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, ci, di, mw0;
        int cpu_t [2];
        int dma_t [2];
        int rd_t [3];
        logic [7:0] rd_v [3];

        repeat (2) tick();
        reset = 1'b0;
        tick();

        // CPU read after reset.
        mw0 = mw_cnt;
        cpu_addr = 8'h10; cpu_write = 1'b0; cpu_req = 1'b1;
        wait_ack(1'b0, n);
        check("t1_latency", n, 3);
        check("t1_rdata", cpu_rdata, 8'hA5);
        check("t1_no_write", mw_cnt - mw0, 0);
        cpu_req = 1'b0;
        tick();

        // DMA write, then CPU reads it back.
        mw0 = mw_cnt;
        dma_addr = 8'h20; dma_wdata = 8'h3C; dma_write = 1'b1; dma_req = 1'b1;
        wait_ack(1'b1, n);
        check("t2_wr_latency", n, 3);
        check("t2_strobe_count", mw_cnt - mw0, 1);
        check("t2_strobe_addr", mw_addr, 8'h20);
        dma_req = 1'b0; dma_write = 1'b0;
        tick();
        cpu_addr = 8'h20; cpu_req = 1'b1;
        wait_ack(1'b0, n);
        check("t2_rd_latency", n, 3);
        check("t2_rdata", cpu_rdata, 8'h3C);
        cpu_req = 1'b0;

        // Simultaneous requests right after reset: CPU first, then strict alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_addr = 8'h10; dma_addr = 8'h03; cpu_req = 1'b1; dma_req = 1'b1;
        ci = 0; di = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (cpu_ack === 1'b1 && ci < 2) begin cpu_t[ci] = k; ci++; end
            if (dma_ack === 1'b1 && di < 2) begin dma_t[di] = k; di++; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("t3_cpu_acks", ci, 2);
        check("t3_dma_acks", di, 2);
        check("t3_cpu_t0", cpu_t[0], 3);
        check("t3_dma_t0", dma_t[0], 6);
        check("t3_cpu_t1", cpu_t[1], 9);
        check("t3_dma_t1", dma_t[1], 12);
        check("t3_dma_rdata", dma_rdata, 8'h33);
        tick();

        // CPU holds req across three reads, changing the address in each ack cycle.
        ci = 0;
        cpu_addr = 8'h01; cpu_req = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (cpu_ack === 1'b1 && ci < 3) begin
                rd_t[ci] = k; rd_v[ci] = cpu_rdata; ci++;
                cpu_addr = cpu_addr + 8'h01;
                if (ci == 3) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check("t4_count", ci, 3);
        check("t4_t0", rd_t[0], 3);
        check("t4_t1", rd_t[1], 7);
        check("t4_t2", rd_t[2], 11);
        check("t4_d0", rd_v[0], 8'h11);
        check("t4_d1", rd_v[1], 8'h22);
        check("t4_d2", rd_v[2], 8'h33);

        // Reset during WAIT of a DMA read.
        dma_addr = 8'h10; dma_write = 1'b0; dma_req = 1'b1;
        tick();
        tick();
        reset = 1'b1; dma_req = 1'b0;
        tick();
        reset = 1'b0;
        check("t5_dma_ack", dma_ack, 1'b0);
        check("t5_owner", owner, 2'b00);
        check("t5_mem_addr", mem_addr, 8'h00);
        check("t5_dma_rdata", dma_rdata, 8'h00);
        check("t5_cpu_rdata", cpu_rdata, 8'h00);
        repeat (3) tick();
        dma_addr = 8'h02; dma_req = 1'b1;
        wait_ack(1'b1, n);
        check("t5_latency", n, 3);
        check("t5_rdata", dma_rdata, 8'h22);
        dma_req = 1'b0;
        tick();

        // Reset in the ISSUE cycle of a CPU write: RAM still written, no ack.
        mw0 = mw_cnt;
        cpu_addr = 8'h40; cpu_wdata = 8'h77; cpu_write = 1'b1; cpu_req = 1'b1;
        tick();
        reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0;
        tick();
        reset = 1'b0;
        check("t6_cpu_ack", cpu_ack, 1'b0);
        check("t6_strobe_count", mw_cnt - mw0, 1);
        check("t6_strobe_addr", mw_addr, 8'h40);
        check("t6_strobe_data", mw_data, 8'h77);
        repeat (2) tick();
        check("t6_no_late_ack", cpu_ack, 1'b0);
        cpu_addr = 8'h40; cpu_req = 1'b1;
        wait_ack(1'b0, n);
        check("t6_rd_latency", n, 3);
        check("t6_rdata", cpu_rdata, 8'h77);
        cpu_req = 1'b0;

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
